// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw level source and the debounce_sync conditioner.
// The master drives the raw level; the slave returns the clean level, edge pulses and busy.
interface debounce_sync_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, input dout, input rise, input fall, input busy);
  modport slave  (input din, output dout, output rise, output fall, output busy);
endinterface

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level and accepts a new level only after
// COUNT_MAX consecutive equal samples; reports the clean level plus edge pulses.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_MAX   = 4
) (
  input logic            CLK,
  input logic            Reset,
  debounce_sync_if.slave bus
);

  localparam int CW = $clog2(COUNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(COUNT_MAX - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   dout_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A wrong-level sample during a WAIT state discards the candidate; the counter
  // is capped at COUNT_MAX-1 because acceptance happens on that value.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            state  <= WAIT_HI;
            cnt    <= CW'(1);
            busy_q <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            busy_q <= 1'b0;
            dout_q <= 1'b1;
            rise_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state  <= WAIT_LO;
            cnt    <= CW'(1);
            busy_q <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            busy_q <= 1'b0;
            dout_q <= 1'b0;
            fall_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= STABLE_LO;
          cnt    <= '0;
          busy_q <= 1'b0;
          dout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage for a raw, asynchronous, possibly bouncing level signal (push-button, switch, external strobe). It synchronises the signal into the `CLK` domain, rejects glitches shorter than a programmable number of cycles, and presents a clean registered level plus single-cycle edge pulses. It sits directly upstream of the D flip-flop stage: `dout` drives that stage's `D` input.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal range is 2 or more.
- `COUNT_MAX`, default 4: consecutive synchronised samples required to accept a new level; legal range is 2 or more.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset; all flops clear immediately on assertion.
- `din` input 1: raw asynchronous level; no timing relationship to `CLK`.
- `dout` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse, registered, when `dout` goes 0→1.
- `fall` output 1: one-cycle pulse, registered, when `dout` goes 1→0.
- `busy` output 1: high while a candidate level change is being qualified (FSM in a WAIT state).

## Operation
- **Synchroniser:** a chain of `SYNC_STAGES` flops; `s` is the last-stage output. The FSM sees only `s`, never `din`.
- **Counter:** `cnt` has width $clog2(COUNT_MAX).
- **FSM states:** STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. `dout` = 1 in STABLE_HI and WAIT_LO; `dout` = 0 otherwise.
- **STABLE_LO:** if `s`=1, go to WAIT_HI with `cnt`←1; otherwise stay.
- **WAIT_HI:**
  - If `s`=0, return to STABLE_LO with `cnt`←0. No output change.
  - If `s`=1 and `cnt`=`COUNT_MAX`-1, go to STABLE_HI, `cnt`←0, `rise`←1 for one cycle.
  - Otherwise, `cnt`←`cnt`+1.
- **STABLE_HI / WAIT_LO:** mirror image of the above with polarity swapped; acceptance pulses `fall`.
- **Acceptance rule:** a level is accepted only after exactly `COUNT_MAX` consecutive equal samples of `s`. A run of `COUNT_MAX`-1 samples is rejected.
- **`busy`:** 1 exactly in WAIT_HI and WAIT_LO.
- **Pulse exclusivity:** `rise` and `fall` are never high in the same cycle. Neither is ever high for two consecutive cycles.
- **Reset values:** all sync flops 0, state STABLE_LO, `cnt` 0, `dout` 0, `rise` 0, `fall` 0, `busy` 0.
- **Reset mid-qualification:** the pending change is discarded; no pulse is emitted.
- **Reset release:**
  - Resumes from STABLE_LO.
  - If `din` is held at 1 through reset, `dout` rises after the normal latency and `rise` pulses once.
- **Counter overflow:** `cnt` never exceeds `COUNT_MAX`-1, so no wrap-around is possible.

## Timing
- **Latency:** `din` stable from before rising edge E0 → `dout`, `rise`/`fall` change after edge E0+`SYNC_STAGES`+`COUNT_MAX`-1. With defaults, that is after the 6th rising edge counting E0.
- **Edge pulse:** `rise`/`fall` assert in the same cycle that `dout` changes, and deassert after the next edge.
- **Minimum accepted pulse:** `COUNT_MAX` cycles high at `s`. Shorter runs leave `dout`, `rise` and `fall` untouched.
- **Bounce during WAIT:** resets qualification. A new run restarts from `cnt`=1 on the next opposite sample.
- **`Reset` assertion:** takes effect without a clock edge. Outputs are 0 within the same delta.
- **`Reset` deassertion:** synchronous in effect; the first state update occurs on the first rising edge after release.
- **Bench clock:** 100 ps period (50 ps half period). Drive `din` on the falling edge; check 1 time unit after the rising edge.

## Test plan
- **Reset values:** assert `Reset` with `din`=1, mid-run → `dout`=`rise`=`fall`=`busy`=0 immediately, with no clock edge needed.
- **Clean rise:** `din` 0→1, held 10 cycles (defaults) → `busy`=1 from edge 3 to edge 5. `dout`=1 and `rise`=1 after edge 6, for exactly one cycle. `fall` stays 0.
- **Glitch reject:** `din` high for 3 cycles, then low → `busy` pulses, `dout` stays 0, `rise` never asserts.
- **Bounce then settle:** `din` pattern 1,0,1,1,0,1,1,1,1,1 → exactly one `rise`. It occurs `SYNC_STAGES`+`COUNT_MAX`-1 edges after the final settling 1.
- **Clean fall:** from `dout`=1, `din`→0 held → `dout`=0 and `fall`=1 for one cycle after the 6th edge.
- **Reset during WAIT_HI:** assert `Reset` while `busy`=1, release with `din`=1 → no pulse during reset. Exactly one `rise` at full latency after release.
